// File: rtl/irrigation_pkg.sv
// Shared types and default timing constants for the
// irrigation cycle scheduler.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_EVAL   = 3'd2,
    ST_WATER  = 3'd3,
    ST_COOL   = 3'd4,
    ST_CONFIG = 3'd5
  } state_e;

  localparam int unsigned TICKS_PER_SEC_DEF = 50_000_000;
  localparam int unsigned COOLDOWN_SEC_DEF  = 10;
  localparam int unsigned MAX_IRR_SEC_DEF   = 120;
  localparam int unsigned TIMEOUT_TICKS_DEF = 1_000_000;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: a single-cycle tick every TICKS
// cycles, restarted from zero by a synchronous clear.
module sec_tick_gen #(
  parameter int unsigned TICKS = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // wrap at LAST, restart on clear
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  assign tick_o = (cnt_q == LAST);

  // prescaler register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/irrigation_cycle_scheduler.sv
// Sequencer for one measure/decide/water/cooldown cycle,
// with parameter-bank arbitration for the keypad.
module irrigation_cycle_scheduler
  import irrigation_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int unsigned COOLDOWN_SEC  = COOLDOWN_SEC_DEF,
  parameter int unsigned MAX_IRR_SEC   = MAX_IRR_SEC_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       adc_valid,
  input  logic       fuzzy_done,
  input  logic [7:0] irrigation_time,
  input  logic       rain_present,
  input  logic       cfg_req,
  output logic       cfg_gnt,
  output logic       sensor_enable,
  output logic       fuzzy_start,
  output logic       pump_on,
  output logic       watering_in_progress,
  output logic [7:0] watering_timer,
  output logic [2:0] state_dbg,
  output logic [7:0] abort_count,
  output logic       timeout_err
);

  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
  localparam int CDW =
    (COOLDOWN_SEC > 0) ? $clog2(COOLDOWN_SEC + 1) : 1;
  localparam logic [TOW-1:0] TO_LAST =
    TOW'(TIMEOUT_TICKS - 1);
  localparam logic [CDW-1:0] CD_LAST =
    CDW'(COOLDOWN_SEC - 1);
  localparam logic [7:0] MAX_IRR = 8'(MAX_IRR_SEC);

  state_e         state_q, state_d;
  logic [7:0]     timer_q, timer_d;
  logic [TOW-1:0] to_q, to_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [7:0]     abort_q, abort_d;
  logic           terr_q, terr_d;
  logic           sen_q, fs_q, pump_q, gnt_q;
  logic           tick, tick_clr, abort_w;

  assign abort_w = (state_q == ST_WATER) &&
                   (rain_present || !enable);

  // prescaler runs only while a timed phase is live
  assign tick_clr = !((state_q == ST_WATER && !abort_w) ||
                      state_q == ST_COOL);

  sec_tick_gen #(
    .TICKS(TICKS_PER_SEC)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(reset),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    to_d    = '0;
    cd_d    = cd_q;
    abort_d = abort_q;
    terr_d  = terr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_req)     state_d = ST_CONFIG;
        else if (enable) state_d = ST_SAMPLE;
      end
      ST_CONFIG: begin
        if (!cfg_req) state_d = ST_IDLE;
      end
      ST_SAMPLE: begin
        if (adc_valid) begin
          state_d = ST_EVAL;
        end else if (to_q == TO_LAST) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_EVAL: begin
        if (fuzzy_done) begin
          cd_d = '0;
          if (rain_present || irrigation_time == 8'd0) begin
            state_d = ST_COOL;
          end else begin
            state_d = ST_WATER;
            timer_d = (irrigation_time > MAX_IRR) ?
                      MAX_IRR : irrigation_time;
          end
        end else if (to_q == TO_LAST) begin
          state_d = ST_IDLE;
          terr_d  = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WATER: begin
        if (abort_w) begin
          state_d = ST_COOL;
          timer_d = 8'd0;
          cd_d    = '0;
          if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            state_d = ST_COOL;
            cd_d    = '0;
          end
        end
      end
      ST_COOL: begin
        if (tick) begin
          if (cd_q == CD_LAST) state_d = ST_IDLE;
          else                 cd_d = cd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counters and Moore outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      to_q    <= '0;
      cd_q    <= '0;
      abort_q <= '0;
      terr_q  <= 1'b0;
      sen_q   <= 1'b0;
      fs_q    <= 1'b0;
      pump_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      to_q    <= to_d;
      cd_q    <= cd_d;
      abort_q <= abort_d;
      terr_q  <= terr_d;
      sen_q   <= (state_d == ST_SAMPLE);
      fs_q    <= (state_q == ST_SAMPLE) &&
                 (state_d == ST_EVAL);
      pump_q  <= (state_d == ST_WATER);
      gnt_q   <= (state_d == ST_CONFIG);
    end
  end

  assign cfg_gnt              = gnt_q;
  assign sensor_enable        = sen_q;
  assign fuzzy_start          = fs_q;
  assign pump_on              = pump_q;
  assign watering_in_progress = pump_q;
  assign watering_timer       = timer_q;
  assign state_dbg            = state_q;
  assign abort_count          = abort_q;
  assign timeout_err          = terr_q;

endmodule

// File: doc/irrigation_cycle_scheduler.md
Name: irrigation_cycle_scheduler

Overview:
Central sequencer for the automatic irrigation system. It runs one measurement→decision→watering→cooldown cycle at a time. It drives the ADC sensor enable, launches the fuzzy evaluation, times the pump in seconds and aborts on rain. It also owns the parameter bank: keypad writes are granted only while no cycle is active. It sits between the ADC/fuzzy datapath, the pump driver, the keypad and the LCD status path.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per one-second tick
COOLDOWN_SEC, 10, idle seconds after every watering or skip decision
MAX_IRR_SEC, 120, clamp for the commanded irrigation time (≤255)
TIMEOUT_TICKS, 1_000_000, max cycles spent waiting for adc_valid or fuzzy_done

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  automatic mode enable (level)
adc_valid  in  1  one-cycle pulse: conversion results stable
fuzzy_done  in  1  one-cycle pulse: irrigation_time/rain_present valid
irrigation_time  in  8  fuzzy output, seconds
rain_present  in  1  rain flag from fuzzy stage (level)
cfg_req  in  1  keypad requests parameter-bank access (level)
cfg_gnt  out  1  access granted (level)
sensor_enable  out  1  ADC sampling enable
fuzzy_start  out  1  one-cycle evaluation trigger
pump_on  out  1  pump drive
watering_in_progress  out  1  high in WATER
watering_timer  out  8  remaining watering seconds
state_dbg  out  3  current state encoding
abort_count  out  8  rain/enable aborts, saturating at 255
timeout_err  out  1  sticky handshake-timeout flag

Behaviour:
- Reset is asynchronous and active-low (reset=0). State is IDLE. All outputs, the timers, the prescaler and abort_count are 0. timeout_err is cleared only by reset.
- All outputs are registered and reflect the current state (Moore). There are no combinational input→output paths.
- States and encodings: IDLE=0, SAMPLE=1, EVAL=2, WATER=3, COOLDOWN=4, CONFIG=5.
- IDLE:
  - cfg_req=1 → CONFIG. cfg_req has priority over enable.
  - Otherwise enable=1 → SAMPLE.
- CONFIG:
  - cfg_gnt=1 throughout. No other output is active.
  - cfg_req=0 → IDLE. cfg_gnt drops in the same cycle as the state change.
- SAMPLE:
  - sensor_enable=1.
  - adc_valid at cycle n → EVAL at n+1, with fuzzy_start=1 for exactly cycle n+1.
  - No adc_valid within TIMEOUT_TICKS cycles → set timeout_err, go to IDLE.
- EVAL:
  - On fuzzy_done, sample irrigation_time and rain_present in that cycle.
  - rain_present=1 or irrigation_time=0 → COOLDOWN (skip watering).
  - Otherwise → WATER with watering_timer = min(irrigation_time, MAX_IRR_SEC).
  - Timeout is handled as in SAMPLE.
  - fuzzy_done arriving in any other state is ignored.
- WATER:
  - pump_on=1 and watering_in_progress=1 from the first WATER cycle.
  - The prescaler clears on entry. Each TICKS_PER_SEC cycles produce one tick, and each tick decrements watering_timer.
  - The tick that brings watering_timer to 0 → COOLDOWN. pump_on is 0 in the next cycle. Watering therefore lasts exactly N×TICKS_PER_SEC cycles.
- Abort (WATER only):
  - Trigger: rain_present=1 or enable=0.
  - Next cycle: state COOLDOWN, pump_on=0, watering_timer=0, abort_count incremented (holds at 255).
  - If abort and tick occur in the same cycle, the abort wins.
- COOLDOWN:
  - The prescaler clears on entry. After COOLDOWN_SEC ticks → IDLE.
  - enable is ignored here. cfg_req is deferred until IDLE.
- cfg_req is never granted in SAMPLE, EVAL, WATER or COOLDOWN. cfg_gnt=0 in those states.
- Mid-operation reset: the pump turns off immediately (asynchronously). The block restarts in IDLE.
- Widths:
  - Prescaler width is $clog2(TICKS_PER_SEC).
  - The timeout counter width is $clog2(TIMEOUT_TICKS+1).
  - The cooldown counter width is $clog2(COOLDOWN_SEC+1).

Decomposition:
- Shared package irrigation_pkg holds:
  - the state enum and its encodings;
  - default constants for TICKS_PER_SEC, COOLDOWN_SEC, MAX_IRR_SEC and TIMEOUT_TICKS.
- One sub-module, sec_tick_gen: a prescaler with synchronous clear that produces a one-cycle tick every TICKS_PER_SEC cycles. The scheduler uses it for both WATER and COOLDOWN timing.

Test Plan:
Bench parameters for all scenarios: TICKS_PER_SEC=4, COOLDOWN_SEC=2, MAX_IRR_SEC=60, TIMEOUT_TICKS=16.
- Normal cycle: enable=1, adc_valid at cycle 5, fuzzy_done with irrigation_time=3, rain_present=0 → fuzzy_start at cycle 6 only; pump_on high for exactly 12 cycles; watering_timer steps 3,2,1,0; 8 cycles in COOLDOWN; then a new SAMPLE.
- Clamp/skip: irrigation_time=200 → watering_timer loads 60. irrigation_time=0 → straight to COOLDOWN with pump_on never asserted.
- Rain abort: rain_present=1 after 5 WATER cycles → pump_on=0 and watering_timer=0 in the next cycle; abort_count=1; state_dbg=4.
- Timeout: no adc_valid for 16 cycles → timeout_err=1, state IDLE. timeout_err stays 1 through later normal cycles until reset.
- Config arbitration:
  - cfg_req raised during WATER → cfg_gnt stays 0 until IDLE, then rises.
  - cfg_req and enable both high in IDLE → CONFIG is taken.
  - Releasing cfg_req → IDLE → SAMPLE.
- Async reset: reset=0 mid-WATER → pump_on, watering_timer and abort_count read 0 before the next clk edge; state_dbg=0.
